// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - CPU fetch stage: program counter, instruction register, redirect, stall, fetch counter
//
// Ports:
//   clock, reset_n             clock (rising edge), asynchronous active-low reset
//   enable                     1 = advance fetch, 0 = stall (hold state)
//   jump_valid, jump_address   redirect from execute; wins over stall and advance
//   mem_address                combinational address to instruction memory (= fetch_pc)
//   mem_instruction            word returned by instruction memory in the same cycle
//   instruction                registered instruction for decode (0 = NOP bubble)
//   instruction_valid          instruction is a real in-path instruction
//   pc                         address of the word held in instruction
//   fetch_count                saturating count of valid captures since reset
//   bp_enable, bp_address,     hardware breakpoint, present only when the
//   resume, halted             FETCH_BREAKPOINT_EN macro is defined
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_address,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_instruction,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instruction_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           fetch_count
`ifdef FETCH_BREAKPOINT_EN
  ,
  input  logic                  bp_enable,
  input  logic [ADDR_WIDTH-1:0] bp_address,
  input  logic                  resume,
  output logic                  halted
`endif
);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  running;
  logic                  capture;

  assign mem_address = fetch_pc;

  // A capture needs the fetch unit running, enabled, and no redirect this cycle.
  assign capture = running && enable && !jump_valid;

`ifdef FETCH_BREAKPOINT_EN
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  state_t state, state_next;
  logic   bp_hit;

  // Jump suppresses capture, so it also overrides the breakpoint.
  assign bp_hit = capture && bp_enable && (fetch_pc == bp_address);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (bp_hit) state_next = HALT;
      HALT:    if (resume) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    halted  = (state == HALT);
  end
`else
  assign running = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc          <= RESET_ADDR;
      instruction       <= '0;
      instruction_valid <= 1'b0;
      pc                <= '0;
      fetch_count       <= '0;
    end else if (jump_valid) begin
      // Redirect inserts a bubble; pc keeps the last delivered address.
      fetch_pc          <= jump_address;
      instruction       <= '0;
      instruction_valid <= 1'b0;
    end else if (capture) begin
      instruction       <= mem_instruction;
      pc                <= fetch_pc;
      instruction_valid <= 1'b1;
      fetch_pc          <= fetch_pc + 1'b1;
      if (fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end else if (!running) begin
      instruction_valid <= 1'b0;
    end
  end

endmodule
